// File: rtl/branch_resolve_if.sv
// Fetch/execute-side handshake bundle for branch_resolve: prediction records in,
// resolutions in, redirect and predictor-training strobes out.
interface branch_resolve_if;
  logic        pred_valid;
  logic        pred_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_cond;
  logic        ex_valid;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_branch;
  logic        upd_result;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target, pred_cond,
    output ex_valid, ex_taken, ex_target,
    input  pred_ready, redirect_valid, redirect_pc, upd_branch, upd_result
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target, pred_cond,
    input  ex_valid, ex_taken, ex_target,
    output pred_ready, redirect_valid, redirect_pc, upd_branch, upd_result
  );
endinterface

// File: rtl/branch_resolve.sv
// In-order prediction FIFO that checks each prediction against the execute
// outcome, issues redirects, trains the predictor and keeps perf counters.
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  branch_resolve_if.slave          br,
  input  logic                     ext_flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic                     underflow_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        cond;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             redirect_valid_reg;
  logic [31:0]      redirect_pc_reg;
  logic             upd_branch_reg;
  logic             upd_result_reg;
  logic [CNT_W-1:0] branch_cnt_reg;
  logic [CNT_W-1:0] mispred_cnt_reg;
  logic             underflow_reg;

  rec_t        head_rec;
  logic        do_push, do_pop, mispred, wr_en;
  logic [31:0] correct_pc;

  assign head_rec      = mem[head_reg];
  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign br.pred_ready = (occ_reg != OCC_W'(DEPTH));
  assign do_push       = br.pred_valid && br.pred_ready;
  assign do_pop        = br.ex_valid && (occ_reg != '0);
  assign mispred       = do_pop && ((head_rec.taken != br.ex_taken) ||
                                    (br.ex_taken && (head_rec.target != br.ex_target)));
  assign correct_pc    = br.ex_taken ? br.ex_target : head_rec.pc + 32'd4;

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    wr_en     = 1'b0;
    if (do_pop)
      head_next = head_reg + PTR_W'(1);
    // Both flush sources collapse the queue onto the post-pop head; pushes are wrong-path.
    if (ext_flush || mispred) begin
      occ_next  = '0;
      tail_next = head_next;
    end else begin
      wr_en    = do_push;
      if (do_push)
        tail_next = tail_reg + PTR_W'(1);
      occ_next = occ_reg + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[tail_reg] <= '{pc: br.pred_pc, taken: br.pred_taken,
                         target: br.pred_target, cond: br.pred_cond};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg           <= '0;
      tail_reg           <= '0;
      occ_reg            <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      upd_branch_reg     <= 1'b0;
      upd_result_reg     <= 1'b0;
      branch_cnt_reg     <= '0;
      mispred_cnt_reg    <= '0;
      underflow_reg      <= 1'b0;
    end else begin
      head_reg           <= head_next;
      tail_reg           <= tail_next;
      occ_reg            <= occ_next;
      redirect_valid_reg <= mispred;
      upd_branch_reg     <= do_pop && head_rec.cond;
      if (mispred)
        redirect_pc_reg <= correct_pc;
      if (do_pop) begin
        upd_result_reg <= br.ex_taken;
        branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
      end
      if (mispred)
        mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
      if (br.ex_valid && (occ_reg == '0))
        underflow_reg <= 1'b1;
    end
  end

  assign br.redirect_valid = redirect_valid_reg;
  assign br.redirect_pc    = redirect_pc_reg;
  assign br.upd_branch     = upd_branch_reg;
  assign br.upd_result     = upd_result_reg;
  assign occupancy         = occ_reg;
  assign branch_cnt        = branch_cnt_reg;
  assign mispred_cnt       = mispred_cnt_reg;
  assign underflow_err     = underflow_reg;
endmodule
